// File: rtl/too_small_norm.sv
// Iterative left-normalizer for the ADDSUB1 subtract path: shifts out leading zeros one
// bit per clock, flushing to signed zero when the exponent runs out.
//
// state | meaning
// IDLE  | waiting for start; result/flags hold last decision
// SHIFT | normalizing m_reg/e_reg, one left shift per clock
module too_small_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [23:0] mant,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        underflow,
  output logic        zero
);

  typedef enum logic {IDLE, SHIFT} stateT;

  stateT       state;
  logic        sReg;
  logic [7:0]  eReg;
  logic [23:0] mReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'h0;
      underflow <= 1'b0;
      zero      <= 1'b0;
      sReg      <= 1'b0;
      eReg      <= 8'h0;
      mReg      <= 24'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sReg  <= sign;
            eReg  <= exp;
            mReg  <= mant;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (mReg == 24'h0) begin
            result    <= {sReg, 31'h0};
            zero      <= 1'b1;
            underflow <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (eReg == 8'h0) begin
            result    <= {sReg, 31'h0};
            zero      <= 1'b1;
            underflow <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (mReg[23]) begin
            result    <= {sReg, eReg, mReg[22:0]};
            zero      <= 1'b0;
            underflow <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (eReg == 8'h1) begin
            // Stop here rather than decrement to 0: denormals are never produced.
            result    <= {sReg, 31'h0};
            zero      <= 1'b1;
            underflow <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            mReg <= {mReg[22:0], 1'b0};
            eReg <= eReg - 8'h1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
